athos_ip_host_seq: RTL and testbench

Command-side sequencer that drives the athos_ip control unit from the system side. It accepts one operation command and streams NUM_WORDS input words into the IP with load/load_en strobes. It then starts the computation, waits for the IP's completion status, and drains NUM_WORDS result words into an output stream before raising a one-cycle done interrupt. It sits between the bus/DMA front-end and athos_ip, replacing software polling of the IP control registers.

---
 rtl/athos_ip_host_seq.sv | 211 +++++++++++++++++++++
 tb/tb_athos_ip_host_seq.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/athos_ip_host_seq.sv
// Host-side sequencer for athos_ip: streams NUM_WORDS words into the IP, starts it, waits for
// completion under a timeout, then drains NUM_WORDS results into a valid/ready output stream.
module athos_ip_host_seq #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned NUM_WORDS   = 256,
    parameter int unsigned TIMEOUT_CYC = 4096,
    localparam int unsigned IDX_W      = $clog2(NUM_WORDS),
    localparam int unsigned CNT_W      = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [5:0]        cmd_op_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              load_o,
    output logic              start_o,
    output logic              store_o,
    output logic              load_en_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [IDX_W-1:0]  wr_idx_o,
    output logic [5:0]        operation_o,
    input  logic              status_0_i,
    output logic [IDX_W-1:0]  rd_idx_o,
    output logic              rd_req_o,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              busy_o,
    output logic              done_intr_o,
    output logic              err_o
);

    localparam logic [IDX_W-1:0] LastIdx  = IDX_W'(NUM_WORDS - 1);
    localparam logic [IDX_W:0]   NumWords = (IDX_W + 1)'(NUM_WORDS);
    localparam logic [CNT_W-1:0] TmoLast  = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoadCmd,
        StLoad,
        StStart,
        StWait,
        StStoreCmd,
        StStore,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [5:0]         op_q, op_d;
    logic               err_q, err_d;
    logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
    logic [CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
    logic [IDX_W:0]     rd_cnt_q, rd_cnt_d;
    logic [IDX_W-1:0]   hs_cnt_q, hs_cnt_d;
    logic               pend_q, pend_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               out_hs;
    logic               rd_fire;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            op_q        <= '0;
            err_q       <= 1'b0;
            wr_idx_q    <= '0;
            tmo_cnt_q   <= '0;
            rd_idx_q    <= '0;
            rd_cnt_q    <= '0;
            hs_cnt_q    <= '0;
            pend_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            err_q       <= err_d;
            wr_idx_q    <= wr_idx_d;
            tmo_cnt_q   <= tmo_cnt_d;
            rd_idx_q    <= rd_idx_d;
            rd_cnt_q    <= rd_cnt_d;
            hs_cnt_q    <= hs_cnt_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        err_d       = err_q;
        wr_idx_d    = wr_idx_q;
        tmo_cnt_d   = tmo_cnt_q;
        rd_idx_d    = rd_idx_q;
        rd_cnt_d    = rd_cnt_q;
        hs_cnt_d    = hs_cnt_q;
        pend_d      = pend_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        cmd_ready_o = 1'b0;
        in_ready_o  = 1'b0;
        load_en_o   = 1'b0;
        load_o      = 1'b0;
        start_o     = 1'b0;
        store_o     = 1'b0;
        rd_req_o    = 1'b0;
        done_intr_o = 1'b0;
        out_hs      = out_valid_q & out_ready_i;
        rd_fire     = 1'b0;

        unique case (state_q)
            StIdle: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    op_d    = cmd_op_i;
                    err_d   = 1'b0;
                    state_d = (cmd_op_i == 6'd0) ? StDone : StLoadCmd;
                end
            end
            StLoadCmd: begin
                load_o   = 1'b1;
                wr_idx_d = '0;
                state_d  = StLoad;
            end
            StLoad: begin
                in_ready_o = 1'b1;
                load_en_o  = in_valid_i;
                if (in_valid_i) begin
                    if (wr_idx_q == LastIdx) begin
                        wr_idx_d = '0;
                        state_d  = StStart;
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
            StStart: begin
                start_o   = 1'b1;
                tmo_cnt_d = '0;
                state_d   = StWait;
            end
            StWait: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                // Completion takes priority over a timeout expiring in the same cycle.
                if (status_0_i) begin
                    tmo_cnt_d = '0;
                    state_d   = StStoreCmd;
                end else if (tmo_cnt_q == TmoLast) begin
                    tmo_cnt_d = '0;
                    err_d     = 1'b1;
                    state_d   = StDone;
                end
            end
            StStoreCmd: begin
                store_o     = 1'b1;
                rd_idx_d    = '0;
                rd_cnt_d    = '0;
                hs_cnt_d    = '0;
                pend_d      = 1'b0;
                out_valid_d = 1'b0;
                state_d     = StStore;
            end
            StStore: begin
                // A request is only issued when the output slot will be free for its data.
                rd_fire  = !pend_q && (rd_cnt_q != NumWords) && (!out_valid_q || out_ready_i);
                rd_req_o = rd_fire;
                if (out_hs) begin
                    out_valid_d = 1'b0;
                    hs_cnt_d    = hs_cnt_q + 1'b1;
                end
                if (pend_q) begin
                    out_data_d  = rdata_i;
                    out_valid_d = 1'b1;
                    pend_d      = 1'b0;
                end
                if (rd_fire) begin
                    pend_d   = 1'b1;
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    rd_idx_d = (rd_idx_q == LastIdx) ? '0 : rd_idx_q + 1'b1;
                end
                if (out_hs && (hs_cnt_q == LastIdx)) begin
                    rd_idx_d = '0;
                    rd_cnt_d = '0;
                    hs_cnt_d = '0;
                    state_d  = StDone;
                end
            end
            StDone: begin
                done_intr_o = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign wdata_o     = in_data_i;
    assign wr_idx_o    = wr_idx_q;
    assign rd_idx_o    = rd_idx_q;
    assign operation_o = op_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign busy_o      = (state_q != StIdle);
    assign err_o       = err_q;

endmodule

// File: tb/tb_athos_ip_host_seq.sv
// Randomised bench for athos_ip_host_seq: a transaction-level IP model plus a per-cycle monitor
// that checks indices, data, stalls and pulse timing against expectations derived from the rules.
module tb_athos_ip_host_seq;

    localparam int unsigned DW  = 32;
    localparam int unsigned NW  = 256;
    localparam int unsigned TMO = 32;
    localparam int unsigned IW  = $clog2(NW);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid_i, cmd_ready_o;
    logic [5:0]    cmd_op_i;
    logic          in_valid_i, in_ready_o;
    logic [DW-1:0] in_data_i;
    logic          load_o, start_o, store_o, load_en_o;
    logic [DW-1:0] wdata_o;
    logic [IW-1:0] wr_idx_o, rd_idx_o;
    logic [5:0]    operation_o;
    logic          status_0_i, rd_req_o;
    logic [DW-1:0] rdata_i;
    logic          out_valid_o, out_ready_i;
    logic [DW-1:0] out_data_o;
    logic          busy_o, done_intr_o, err_o;

    athos_ip_host_seq #(
        .DATA_W      (DW),
        .NUM_WORDS   (NW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_op_i    (cmd_op_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .load_o      (load_o),
        .start_o     (start_o),
        .store_o     (store_o),
        .load_en_o   (load_en_o),
        .wdata_o     (wdata_o),
        .wr_idx_o    (wr_idx_o),
        .operation_o (operation_o),
        .status_0_i  (status_0_i),
        .rd_idx_o    (rd_idx_o),
        .rd_req_o    (rd_req_o),
        .rdata_i     (rdata_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .busy_o      (busy_o),
        .done_intr_o (done_intr_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // IP result memory and test knobs (written by the main sequence only)
    logic [DW-1:0] mem [NW];
    logic [5:0]    exp_op;
    logic          exp_err;
    logic          in_gaps, rdy_rand, st_en, stall_req;
    int            st_delay;

    // Per-operation observations (written by the monitor only; cleared on each accept)
    int n_acc = 0, acc_cyc = 0, busy_cnt = 0;
    int n_loadp = 0, n_load_en = 0, first_load_cyc = -1;
    int n_start = 0, start_cyc = -1, n_store = 0, store_cyc = -1;
    int n_req = 0, first_req_cyc = -1, first_ov_cyc = -1;
    int n_hs = 0, last_hs_cyc = -1, n_done = 0, done_cyc = -1;
    int exp_wr = 0, exp_rd = 0, exp_out = 0;
    logic prev_acc = 1'b0, prev_req = 1'b0, prev_stall = 1'b0, prev_done = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_wr = 0; exp_rd = 0; exp_out = 0;
            prev_acc = 1'b0; prev_req = 1'b0; prev_stall = 1'b0; prev_done = 1'b0;
        end else begin
            chk("cmd_ready_vs_busy", cmd_ready_o, !busy_o);
            chk("wdata_passthru", wdata_o, in_data_i);
            chk("load_en_qual", load_en_o, in_valid_i && in_ready_o);
            if (prev_acc) begin
                chk("err_clr_on_accept", err_o, 1'b0);
                chk("op_latched", operation_o, exp_op);
            end
            prev_acc = cmd_valid_i && cmd_ready_o;
            if (prev_acc) begin
                n_acc++; acc_cyc = cyc; busy_cnt = 0;
                n_loadp = 0; n_load_en = 0; first_load_cyc = -1;
                n_start = 0; start_cyc = -1; n_store = 0; store_cyc = -1;
                n_req = 0; first_req_cyc = -1; first_ov_cyc = -1;
                n_hs = 0; last_hs_cyc = -1; n_done = 0; done_cyc = -1;
                exp_wr = 0; exp_rd = 0; exp_out = 0;
            end
            if (busy_o) busy_cnt++;
            if (load_o) n_loadp++;
            if (load_en_o) begin
                if (first_load_cyc < 0) first_load_cyc = cyc;
                chk("wr_idx", wr_idx_o, exp_wr);
                exp_wr = (exp_wr + 1) % NW;
                n_load_en++;
            end
            if (start_o) begin n_start++; start_cyc = cyc; end
            if (store_o) begin
                n_store++; store_cyc = cyc; first_req_cyc = -1; first_ov_cyc = -1;
            end
            if (rd_req_o) begin
                if (first_req_cyc < 0) first_req_cyc = cyc;
                chk("rd_idx", rd_idx_o, exp_rd);
                chk("req_one_outstanding", prev_req, 1'b0);
                exp_rd = (exp_rd + 1) % NW;
                n_req++;
            end
            prev_req = rd_req_o;
            if (prev_stall) begin
                chk("stall_valid_held", out_valid_o, 1'b1);
                chk("stall_data_stable", out_data_o, prev_data);
            end
            if (out_valid_o && first_ov_cyc < 0) first_ov_cyc = cyc;
            if (out_valid_o && out_ready_i) begin
                chk("out_data", out_data_o, mem[exp_out % NW]);
                exp_out++;
                n_hs++;
                last_hs_cyc = cyc;
            end
            prev_stall = out_valid_o && !out_ready_i;
            prev_data  = out_data_o;
            if (done_intr_o) begin
                chk("done_one_cycle", prev_done, 1'b0);
                chk("err_at_done", err_o, exp_err);
                n_done++;
                done_cyc = cyc;
            end
            prev_done = done_intr_o;
        end
    end

    // IP read port: data appears exactly one cycle after a request
    logic          req_s;
    logic [IW-1:0] idx_s;
    initial begin
        rdata_i = '0;
        forever begin
            @(negedge clk);
            req_s = rd_req_o;
            idx_s = rd_idx_o;
            @(posedge clk);
            #1;
            rdata_i = req_s ? mem[idx_s] : DW'($urandom);
        end
    end

    int   stall_left = 0;
    logic stall_done = 1'b0;
    initial begin
        in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0; status_0_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            in_data_i  = DW'($urandom);
            in_valid_i = in_gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (stall_req && !stall_done && n_hs >= 100) begin
                stall_left = 10;
                stall_done = 1'b1;
            end
            if (stall_left > 0) begin
                out_ready_i = 1'b0;
                stall_left--;
            end else begin
                out_ready_i = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            status_0_i = st_en && (start_cyc >= 0) && (cyc >= start_cyc + st_delay);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic issue_cmd(input logic [5:0] op, input bit hold);
        exp_op = op;
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        @(posedge clk);
        #1;
        if (hold) repeat (5) begin @(posedge clk); #1; end
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int w = 0;
        while (n_done == 0 && w < max_cyc) begin tick(); w++; end
        chk("done_within_budget", n_done != 0, 1'b1);
        tick();
    endtask

    task automatic run_op(input logic [5:0] op, input bit hold, input int max_cyc);
        for (int i = 0; i < NW; i++) mem[i] = DW'($urandom);
        issue_cmd(op, hold);
        wait_done(max_cyc);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready_o, 1'b1);
        chk({tag, "_busy"}, busy_o, 1'b0);
        chk({tag, "_in_ready"}, in_ready_o, 1'b0);
        chk({tag, "_pulses"}, {load_o, start_o, store_o, load_en_o, rd_req_o, done_intr_o}, 6'b0);
        chk({tag, "_wr_idx"}, wr_idx_o, 0);
        chk({tag, "_rd_idx"}, rd_idx_o, 0);
        chk({tag, "_out_valid"}, out_valid_o, 1'b0);
        chk({tag, "_out_data"}, out_data_o, 0);
        chk({tag, "_operation"}, operation_o, 0);
        chk({tag, "_err"}, err_o, 1'b0);
        chk({tag, "_wdata"}, wdata_o, in_data_i);
    endtask

    task automatic check_full_op(input string tag);
        chk({tag, "_loads"}, n_load_en, NW);
        chk({tag, "_load_pulse"}, n_loadp, 1);
        chk({tag, "_start_pulse"}, n_start, 1);
        chk({tag, "_store_pulse"}, n_store, 1);
        chk({tag, "_reads"}, n_req, NW);
        chk({tag, "_out_words"}, n_hs, NW);
        chk({tag, "_done_pulse"}, n_done, 1);
        chk({tag, "_done_after_last"}, done_cyc - last_hs_cyc, 1);
    endtask

    int acc0, loads_at, w;

    initial begin
        rst_n = 1'b0; cmd_valid_i = 1'b0; cmd_op_i = '0;
        in_gaps = 1'b0; rdy_rand = 1'b0; st_en = 1'b0; stall_req = 1'b0; st_delay = 0;
        exp_op = '0; exp_err = 1'b0;
        for (int i = 0; i < NW; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // NULL command: straight to the done pulse, one busy cycle
        acc0 = n_acc;
        run_op(6'd0, 1'b0, 100);
        chk("null_accepts", n_acc - acc0, 1);
        chk("null_no_load", n_loadp, 0);
        chk("null_no_start", n_start, 0);
        chk("null_no_store", n_store, 0);
        chk("null_done_latency", done_cyc - acc_cyc, 1);
        chk("null_busy_cycles", busy_cnt, 1);

        // Op 1, full throughput, status 30 cycles after start, cmd_valid held past accept
        st_en = 1'b1; st_delay = 30;
        acc0 = n_acc;
        run_op(6'd1, 1'b1, 3000);
        check_full_op("op1");
        chk("op1_accepts", n_acc - acc0, 1);
        chk("op1_first_load", first_load_cyc - acc_cyc, 2);
        chk("op1_start_lat", start_cyc - acc_cyc, 2 + NW);
        chk("op1_store_lat", store_cyc - start_cyc, 31);
        chk("op1_first_req", first_req_cyc - store_cyc, 1);
        chk("op1_first_valid", first_ov_cyc - first_req_cyc, 2);
        chk("op1_store_span", last_hs_cyc - store_cyc, 3 + 2 * (NW - 1));

        // Op 5, random input gaps, random ready with a 10-cycle stall mid-store
        in_gaps = 1'b1; rdy_rand = 1'b1; stall_req = 1'b1;
        st_delay = $urandom_range(1, TMO);
        run_op(6'd5, 1'b0, 20000);
        check_full_op("rand");
        chk("rand_stall_applied", stall_done, 1'b1);
        in_gaps = 1'b0; rdy_rand = 1'b0; stall_req = 1'b0;

        // Timeout: status never rises
        st_en = 1'b0; exp_err = 1'b1;
        run_op(6'd2, 1'b0, 1000);
        chk("tmo_no_store", n_store, 0);
        chk("tmo_no_out", n_hs, 0);
        chk("tmo_done_pulse", n_done, 1);
        chk("tmo_done_lat", done_cyc - start_cyc, TMO + 1);
        repeat (3) tick();
        chk("tmo_err_sticky", err_o, 1'b1);

        // Status exactly on the last timeout cycle wins
        st_en = 1'b1; st_delay = TMO; exp_err = 1'b0;
        run_op(6'd3, 1'b0, 3000);
        check_full_op("edge");
        chk("edge_store_lat", store_cyc - start_cyc, TMO + 1);
        chk("edge_err_clear", err_o, 1'b0);

        // Asynchronous reset at load word 100, then a clean restart
        st_delay = 5;
        for (int i = 0; i < NW; i++) mem[i] = DW'($urandom);
        issue_cmd(6'd4, 1'b0);
        w = 0;
        while (n_load_en < 100 && w < 500) begin tick(); w++; end
        chk("rst_reached_word_100", n_load_en, 100);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        loads_at = n_load_en;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) tick();
        chk("rst_no_start", n_start, 0);
        chk("rst_no_done", n_done, 0);
        chk("rst_no_reload", n_loadp, 1);
        chk("rst_loads_frozen", n_load_en, loads_at);
        chk("rst_idle", busy_o, 1'b0);
        run_op(6'd4, 1'b0, 3000);
        check_full_op("restart");
        chk("restart_first_load", first_load_cyc - acc_cyc, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
